// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator side of the data-memory port.
// Turns CPU load/store requests (byte/half/word, byte address) into
// memRead/memWrite cycles on a word-indexed, comb-read/sync-write memory.
// Sub-word stores are done as read-modify-write. Loads are sign- or
// zero-extended. Only one request is in flight at a time.
//
// Ports
//   clk, rst_n                        clock, async active-low reset
//   reqValid/reqReady                 request handshake (reqReady=1 only in IDLE)
//   reqWrite, reqSize, reqSigned      store flag, 00 byte/01 half/10 word, load sign-extend
//   reqAddr[ADDR_W], reqWdata[32]     byte address, right-justified store data
//   respValid, respRdata, respError   one-cycle completion pulse with load data / error
//   memAddress, memDataOut, memDataIn word index, write data, comb read data
//   memRead, memWrite                 memory strobes (never both high)
//
// Build option
//   MEM_ACCESS_STATS_EN : adds readCount[15:0] / writeCount[15:0] saturating
//                         strobe-cycle counters. When undefined these ports
//                         are absent.

module mem_access_unit #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WORD_LIMIT = 101
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [1:0]        reqSize,
  input  logic              reqSigned,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [31:0]       reqWdata,
  output logic              respValid,
  output logic [31:0]       respRdata,
  output logic              respError,
  output logic [31:0]       memAddress,
  output logic [31:0]       memDataOut,
  input  logic [31:0]       memDataIn,
  output logic              memRead,
  output logic              memWrite
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [15:0]       readCount,
  output logic [15:0]       writeCount
`endif
);

  localparam int unsigned IDX_W = ADDR_W - 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_WR     = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0] req_idx;
  logic             req_err_c;
  logic             accept_c;

  // Captured request fields used after the accept edge
  logic [1:0]  cap_size;
  logic [1:0]  cap_lane;
  logic        cap_signed;
  logic [15:0] cap_wdata;

  // Next values of the state-decoded (Moore) outputs
  logic mem_read_nxt, mem_write_nxt, req_ready_nxt, resp_valid_nxt;

  assign req_idx  = reqAddr[ADDR_W-1:2];
  assign accept_c = (state == S_IDLE) && reqValid;

  // Misaligned, illegal size, or word index past the end of memory
  assign req_err_c = (reqSize == 2'b11)
                  || ((reqSize == 2'b01) && reqAddr[0])
                  || ((reqSize == 2'b10) && (reqAddr[1:0] != 2'b00))
                  || (req_idx >= IDX_W'(WORD_LIMIT));

  // Pick the addressed lane and extend it to 32 bits
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Merge new sub-word store data into the lane of the old word
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [15:0] wd,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = word;
    if (size == 2'b00) begin
      case (lane)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0] = wd;
    end
    return r;
  endfunction

  // Next-state and next Moore-output decode
  always_comb begin
    state_nxt      = state;
    mem_read_nxt   = 1'b0;
    mem_write_nxt  = 1'b0;
    req_ready_nxt  = 1'b0;
    resp_valid_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (reqValid) begin
          if (req_err_c)              state_nxt = S_RESP;
          else if (!reqWrite)         state_nxt = S_RD;
          else if (reqSize == 2'b10)  state_nxt = S_WR;
          else                        state_nxt = S_RMW_RD;
        end
      end
      S_RD:     state_nxt = S_RESP;
      S_RMW_RD: state_nxt = S_WR;
      S_WR:     state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    mem_read_nxt   = (state_nxt == S_RD) || (state_nxt == S_RMW_RD);
    mem_write_nxt  = (state_nxt == S_WR);
    req_ready_nxt  = (state_nxt == S_IDLE);
    resp_valid_nxt = (state_nxt == S_RESP);
  end

  // State register with registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      reqReady  <= 1'b1;
      respValid <= 1'b0;
    end else begin
      state     <= state_nxt;
      memRead   <= mem_read_nxt;
      memWrite  <= mem_write_nxt;
      reqReady  <= req_ready_nxt;
      respValid <= resp_valid_nxt;
    end
  end

  // Request capture, memory address/data and response data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memAddress <= 32'h0;
      memDataOut <= 32'h0;
      respRdata  <= 32'h0;
      respError  <= 1'b0;
      cap_size   <= 2'b00;
      cap_lane   <= 2'b00;
      cap_signed <= 1'b0;
      cap_wdata  <= 16'h0;
    end else begin
      if (accept_c) begin
        memAddress <= 32'(req_idx);
        respError  <= req_err_c;
        respRdata  <= 32'h0;
        cap_size   <= reqSize;
        cap_lane   <= reqAddr[1:0];
        cap_signed <= reqSigned;
        cap_wdata  <= reqWdata[15:0];
        if (reqWrite && (reqSize == 2'b10) && !req_err_c)
          memDataOut <= reqWdata;
      end
      if (state == S_RD)
        respRdata <= load_extract(memDataIn, cap_size, cap_lane, cap_signed);
      if (state == S_RMW_RD)
        memDataOut <= store_merge(memDataIn, cap_wdata, cap_size, cap_lane);
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  // Saturating count of cycles with each strobe asserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readCount  <= 16'h0;
      writeCount <= 16'h0;
    end else begin
      if (memRead && (readCount != 16'hFFFF))
        readCount <= readCount + 16'd1;
      if (memWrite && (writeCount != 16'hFFFF))
        writeCount <= writeCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: word memory model, arithmetic reference
// model, queue scoreboard with an independent response monitor.
module tb_mem_access_unit;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WL     = 101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reqValid = 1'b0, reqReady, reqWrite = 1'b0, reqSigned = 1'b0;
  logic [1:0]  reqSize = 2'b00;
  logic [31:0] reqAddr = 32'h0, reqWdata = 32'h0;
  logic        respValid, respError, memRead, memWrite;
  logic [31:0] respRdata, memAddress, memDataOut, memDataIn;
`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] readCount, writeCount;
`endif

  mem_access_unit #(.ADDR_W(ADDR_W), .WORD_LIMIT(WL)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr), .reqWdata(reqWdata),
    .respValid(respValid), .respRdata(respRdata), .respError(respError),
    .memAddress(memAddress), .memDataOut(memDataOut), .memDataIn(memDataIn),
    .memRead(memRead), .memWrite(memWrite)
`ifdef MEM_ACCESS_STATS_EN
    , .readCount(readCount), .writeCount(writeCount)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: comb read, sync write, plus a bench preload port
  logic [31:0] mem [0:WL-1];
  logic        pl_en = 1'b0;
  int unsigned pl_idx = 0;
  logic [31:0] pl_val = 32'h0;
  assign memDataIn = (memAddress < 32'(WL)) ? mem[memAddress[6:0]] : 32'h0;
  always @(posedge clk) begin
    if (memWrite && (memAddress < 32'(WL))) mem[memAddress[6:0]] <= memDataOut;
    if (pl_en) mem[pl_idx] <= pl_val;
  end

  logic [31:0] ref_mem [0:WL-1];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
    int unsigned acc;
    int unsigned rd;
    int unsigned wr;
    logic [31:0] widx;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0, n_bad = 0;
  int unsigned exp_rd = 0, exp_wr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte-lane arithmetic on the reference word array
  task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    int unsigned idx, off, nbytes;
    longint unsigned word, span, val, keep;
    idx = a / 4;
    off = a % 4;
    e.rdata = 32'h0; e.rd = 0; e.wr = 0; e.acc = 0; e.widx = idx;
    e.err = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0) || (idx >= WL);
    if (e.err) begin
      e.lat = 1;
    end else begin
      nbytes = 1 << sz;
      span   = 64'd1 << (8 * nbytes);
      word   = 64'(ref_mem[idx]);
      val    = (word >> (8 * off)) % span;
      if (!w) begin
        if (sg && val >= span / 2) val = val + 64'h1_0000_0000 - span;
        e.rdata = 32'(val);
        e.lat = 2; e.rd = 1;
      end else begin
        keep = word - (val << (8 * off));
        ref_mem[idx] = 32'(keep + ((64'(wd) % span) << (8 * off)));
        e.lat = (sz == 2'd2) ? 2 : 3;
        e.rd  = (sz == 2'd2) ? 0 : 1;
        e.wr  = 1;
      end
    end
  endtask

  task automatic preload(input int unsigned idx, input logic [31:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val; ref_mem[idx] = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Present a request (reqValid left high) and wait for acceptance
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input bit push,
                       output int unsigned acc);
    exp_t e;
    reqWrite = w; reqSize = sz; reqSigned = sg; reqAddr = a; reqWdata = wd; reqValid = 1'b1;
    for (int t = 0; !reqReady; t++) begin
      if (t >= 50) begin
        $display("FAIL accept_timeout: reqReady stuck at %0b, required 1", reqReady);
        $fatal(1);
      end
      @(negedge clk);
    end
    acc = cyc;
    if (push) begin
      model(w, sz, sg, a, wd, e);
      e.acc = acc;
      q.push_back(e);
      exp_rd += e.rd;
      exp_wr += e.wr;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    reqValid = 1'b0;
    for (int t = 0; q.size() != 0; t++) begin
      if (t >= 100) begin
        n_cmp++; n_bad++;
        $display("FAIL drain_timeout: %0d responses outstanding, required 0", q.size());
        q.delete();
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // Monitor: counts strobes per transaction and checks each response
  initial begin
    int unsigned rd_c, wr_c;
    logic both;
    exp_t e;
    rd_c = 0; wr_c = 0; both = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_c = 0; wr_c = 0; both = 1'b0;
      end else begin
        if (memRead) rd_c++;
        if (memWrite) wr_c++;
        if (memRead && memWrite) both = 1'b1;
        if (respValid) begin
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_resp: respValid=1 with no request outstanding");
          end else begin
            e = q.pop_front();
            chk("respRdata", respRdata, e.rdata);
            chk("respError", 32'(respError), 32'(e.err));
            chk("latency", cyc - e.acc, e.lat);
            chk("memAddress", memAddress, e.widx);
            chk("read_cycles", rd_c, e.rd);
            chk("write_cycles", wr_c, e.wr);
            chk("rd_wr_overlap", 32'(both), 32'h0);
          end
          rd_c = 0; wr_c = 0; both = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned acc, acc0, acc1, acc2, idx, off;
    logic [1:0] sz;
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < int'(WL); i++) preload(i, $urandom);
    chk("rst_reqReady", 32'(reqReady), 32'h1);
    chk("rst_respValid", 32'(respValid), 32'h0);
    chk("rst_memStrobes", {30'h0, memRead, memWrite}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_respRdata", respRdata, 32'h0);
    chk("rst_respError", 32'(respError), 32'h0);
    chk("rst_memAddress", memAddress, 32'h0);
    chk("rst_memDataOut", memDataOut, 32'h0);

    // Word load
    preload(20, 32'h11223344);
    issue(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 1'b1, acc);
    drain();
    // Sign/zero-extended sub-word loads
    preload(20, 32'h80223344);
    issue(1'b0, 2'b00, 1'b1, 32'h53, 32'h0, 1'b1, acc);
    issue(1'b0, 2'b00, 1'b0, 32'h53, 32'h0, 1'b1, acc);
    issue(1'b0, 2'b01, 1'b1, 32'h52, 32'h0, 1'b1, acc);
    drain();
    // Sub-word store (read-modify-write) then read back
    preload(20, 32'h11223344);
    issue(1'b1, 2'b00, 1'b0, 32'h51, 32'h000000AB, 1'b1, acc);
    issue(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 1'b1, acc);
    drain();
    chk("sb_merge_mem20", mem[20], 32'h1122AB44);
    // Error cases
    issue(1'b0, 2'b01, 1'b0, 32'h51, 32'h0, 1'b1, acc);
    issue(1'b0, 2'b10, 1'b0, 32'h52, 32'h0, 1'b1, acc);
    issue(1'b0, 2'b11, 1'b0, 32'h50, 32'h0, 1'b1, acc);
    issue(1'b0, 2'b10, 1'b0, 32'h194, 32'h0, 1'b1, acc);
    issue(1'b1, 2'b10, 1'b0, 32'h194, 32'h12345678, 1'b1, acc);
    drain();

    // Reset during the write cycle abandons the store
    preload(21, 32'h01020304);
    issue(1'b1, 2'b10, 1'b0, 32'h54, 32'hDEADBEEF, 1'b0, acc);
    reqValid = 1'b0;
    for (int t = 0; !memWrite && t < 5; t++) @(negedge clk);
    chk("abort_wr_seen", 32'(memWrite), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_memWrite", 32'(memWrite), 32'h0);
    chk("abort_reqReady", 32'(reqReady), 32'h1);
    exp_rd = 0; exp_wr = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_mem21", mem[21], 32'h01020304);

    // Back-to-back word stores with reqValid held high
    issue(1'b1, 2'b10, 1'b0, 32'h54, 32'hCAFE0001, 1'b1, acc0);
    issue(1'b1, 2'b10, 1'b0, 32'h58, 32'hCAFE0002, 1'b1, acc1);
    issue(1'b1, 2'b10, 1'b0, 32'h5C, 32'hCAFE0003, 1'b1, acc2);
    drain();
    chk("b2b_spacing1", acc1 - acc0, 32'd3);
    chk("b2b_spacing2", acc2 - acc1, 32'd3);
`ifdef MEM_ACCESS_STATS_EN
    chk("b2b_writeCount", 32'(writeCount), 32'd3);
`endif

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      sz  = ($urandom_range(0, 9) == 9) ? 2'b11 : 2'($urandom_range(0, 2));
      idx = $urandom_range(0, WL + 2);
      off = $urandom_range(0, 3);
      if ($urandom_range(0, 4) != 0) begin
        if (sz == 2'b01) off = off & 2;
        if (sz == 2'b10) off = 0;
      end
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            32'(idx * 4 + off), $urandom, 1'b1, acc);
      if ($urandom_range(0, 3) == 0) begin
        reqValid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    drain();

    for (int i = 0; i < int'(WL); i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
`ifdef MEM_ACCESS_STATS_EN
    chk("readCount", 32'(readCount), exp_rd);
    chk("writeCount", 32'(writeCount), exp_wr);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
